afe_pulse_capture: RTL and testbench



---
 rtl/afe_pulser_pkg.sv | 15 +
 rtl/afe_pulse_capture_if.sv | 24 ++
 rtl/afe_word_edge_find.sv | 58 +++++
 rtl/afe_pulse_capture.sv | 172 +++++++++++++++++
 tb/tb_afe_pulse_capture.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/afe_pulser_pkg.sv
// Shared definitions for the AFE pulser and its receive-side pulse capture.
package afe_pulser_pkg;

    localparam int NSAMP           = 8;
    localparam int WIDTH_BITS_DEF  = 16;
    localparam int COARSE_BITS_DEF = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        IN_PULSE = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/afe_pulse_capture_if.sv
// Result handshake between the pulse capture block and the slow-control reader.
interface afe_pulse_capture_if
    import afe_pulser_pkg::*;
#(
    parameter int WIDTH_BITS  = WIDTH_BITS_DEF,
    parameter int COARSE_BITS = COARSE_BITS_DEF
);
    logic                   res_valid;
    logic                   res_ready;
    logic [WIDTH_BITS-1:0]  res_width;
    logic [COARSE_BITS-1:0] res_coarse;
    logic [2:0]             res_fine;
    logic                   res_sat;

    modport master (
        output res_valid, res_width, res_coarse, res_fine, res_sat,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_width, res_coarse, res_fine, res_sat,
        output res_ready
    );
endinterface

// File: rtl/afe_word_edge_find.sv
// Combinational edge search over one deserialised word (bit 0 earliest).
module afe_word_edge_find
    import afe_pulser_pkg::*;
(
    input  logic [NSAMP-1:0] din,
    input  logic             y0,
    input  logic             prev_active,
    output logic             lead_found,
    output logic [2:0]       lead_idx,
    output logic             trail_found,
    output logic [2:0]       trail_idx,
    output logic             idle_found,
    output logic [2:0]       idle_idx,
    output logic             lead_after_trail,
    output logic             lead_after_idle
);
    logic [NSAMP-1:0] act;
    logic [NSAMP-1:0] lead;

    always_comb begin
        act              = din ^ {NSAMP{y0}};
        lead             = act & ~{act[NSAMP-2:0], prev_active};
        lead_found       = 1'b0;
        lead_idx         = '0;
        trail_found      = 1'b0;
        trail_idx        = '0;
        idle_found       = 1'b0;
        idle_idx         = '0;
        lead_after_trail = 1'b0;
        lead_after_idle  = 1'b0;

        // Descending scans leave the lowest matching index in place.
        for (int i = NSAMP - 1; i >= 0; i--) begin
            if (lead[i]) begin
                lead_found = 1'b1;
                lead_idx   = 3'(i);
            end
            if (!act[i]) begin
                idle_found = 1'b1;
                idle_idx   = 3'(i);
            end
        end

        for (int j = NSAMP - 1; j >= 0; j--) begin
            if (lead_found && !act[j] && (j > int'(lead_idx))) begin
                trail_found = 1'b1;
                trail_idx   = 3'(j);
            end
        end

        for (int k = 0; k < NSAMP; k++) begin
            if (lead[k] && trail_found && (k > int'(trail_idx)))
                lead_after_trail = 1'b1;
            if (lead[k] && idle_found && (k > int'(idle_idx)))
                lead_after_idle = 1'b1;
        end
    end
endmodule

// File: rtl/afe_pulse_capture.sv
// Measures leading-edge time and width of pulses on an 8:1 deserialised AFE monitor line.
module afe_pulse_capture
    import afe_pulser_pkg::*;
#(
    parameter int WIDTH_BITS  = WIDTH_BITS_DEF,
    parameter int COARSE_BITS = COARSE_BITS_DEF
)(
    input  logic                    lclk,
    input  logic                    lclk_rst_n,
    input  logic [NSAMP-1:0]        din,
    input  logic                    y0,
    input  logic                    arm,
    afe_pulse_capture_if.master     res,
    output logic                    dropped,
    output logic                    busy
);
    state_t                 state_q, state_d;
    logic [COARSE_BITS-1:0] coarse_q, coarse_d;
    logic                   prev_q, prev_d;
    logic                   dropped_q, dropped_d;
    logic [WIDTH_BITS-1:0]  acc_q, acc_d;
    logic                   sat_q, sat_d;
    logic [COARSE_BITS-1:0] cap_coarse_q, cap_coarse_d;
    logic [2:0]             cap_fine_q, cap_fine_d;
    logic                   res_valid_q, res_valid_d;
    logic [WIDTH_BITS-1:0]  res_width_q, res_width_d;
    logic [COARSE_BITS-1:0] res_coarse_q, res_coarse_d;
    logic [2:0]             res_fine_q, res_fine_d;
    logic                   res_sat_q, res_sat_d;

    logic       lead_found, trail_found, idle_found;
    logic [2:0] lead_idx, trail_idx, idle_idx;
    logic       lead_after_trail, lead_after_idle;
    logic [3:0] first_w;
    logic [WIDTH_BITS:0] sum;

    afe_word_edge_find u_edge (
        .din              (din),
        .y0               (y0),
        .prev_active      (prev_q),
        .lead_found       (lead_found),
        .lead_idx         (lead_idx),
        .trail_found      (trail_found),
        .trail_idx        (trail_idx),
        .idle_found       (idle_found),
        .idle_idx         (idle_idx),
        .lead_after_trail (lead_after_trail),
        .lead_after_idle  (lead_after_idle)
    );

    // MSB of the result flags saturation; the low bits are clamped to all-ones.
    function automatic logic [WIDTH_BITS:0] sat_add(input logic [WIDTH_BITS-1:0] a,
                                                    input logic [3:0] b);
        logic [WIDTH_BITS:0] s;
        s = {1'b0, a} + (WIDTH_BITS+1)'(b);
        if (s[WIDTH_BITS])
            return {1'b1, {WIDTH_BITS{1'b1}}};
        return {1'b0, s[WIDTH_BITS-1:0]};
    endfunction

    always_comb begin
        state_d      = state_q;
        coarse_d     = coarse_q + COARSE_BITS'(1);
        prev_d       = prev_q;
        dropped_d    = dropped_q;
        acc_d        = acc_q;
        sat_d        = sat_q;
        cap_coarse_d = cap_coarse_q;
        cap_fine_d   = cap_fine_q;
        res_valid_d  = res_valid_q & ~res.res_ready;
        res_width_d  = res_width_q;
        res_coarse_d = res_coarse_q;
        res_fine_d   = res_fine_q;
        res_sat_d    = res_sat_q;
        first_w      = '0;
        sum          = '0;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d   = ARMED;
                    dropped_d = 1'b0;
                    prev_d    = 1'b1;
                end
            end
            ARMED: begin
                prev_d = din[NSAMP-1] ^ y0;
                if (lead_found) begin
                    cap_coarse_d = coarse_q;
                    cap_fine_d   = lead_idx;
                    sat_d        = 1'b0;
                    if (trail_found) begin
                        first_w = {1'b0, trail_idx} - {1'b0, lead_idx};
                        state_d = DONE;
                        if (lead_after_trail)
                            dropped_d = 1'b1;
                    end else begin
                        first_w = 4'(NSAMP) - {1'b0, lead_idx};
                        state_d = IN_PULSE;
                    end
                    acc_d = WIDTH_BITS'(first_w);
                end
            end
            IN_PULSE: begin
                prev_d = din[NSAMP-1] ^ y0;
                if (idle_found) begin
                    sum     = sat_add(acc_q, {1'b0, idle_idx});
                    state_d = DONE;
                    if (lead_after_idle)
                        dropped_d = 1'b1;
                end else begin
                    sum = sat_add(acc_q, 4'(NSAMP));
                end
                acc_d = sum[WIDTH_BITS-1:0];
                sat_d = sat_q | sum[WIDTH_BITS];
            end
            default: begin
                state_d = IDLE;
                // An unread result wins; a same-cycle handshake frees the slot.
                if (!res_valid_q || res.res_ready) begin
                    res_valid_d  = 1'b1;
                    res_width_d  = acc_q;
                    res_coarse_d = cap_coarse_q;
                    res_fine_d   = cap_fine_q;
                    res_sat_d    = sat_q;
                end else begin
                    dropped_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge lclk or negedge lclk_rst_n) begin
        if (!lclk_rst_n) begin
            state_q      <= IDLE;
            coarse_q     <= '0;
            prev_q       <= 1'b1;
            dropped_q    <= 1'b0;
            acc_q        <= '0;
            sat_q        <= 1'b0;
            cap_coarse_q <= '0;
            cap_fine_q   <= '0;
            res_valid_q  <= 1'b0;
            res_width_q  <= '0;
            res_coarse_q <= '0;
            res_fine_q   <= '0;
            res_sat_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            coarse_q     <= coarse_d;
            prev_q       <= prev_d;
            dropped_q    <= dropped_d;
            acc_q        <= acc_d;
            sat_q        <= sat_d;
            cap_coarse_q <= cap_coarse_d;
            cap_fine_q   <= cap_fine_d;
            res_valid_q  <= res_valid_d;
            res_width_q  <= res_width_d;
            res_coarse_q <= res_coarse_d;
            res_fine_q   <= res_fine_d;
            res_sat_q    <= res_sat_d;
        end
    end

    assign res.res_valid  = res_valid_q;
    assign res.res_width  = res_width_q;
    assign res.res_coarse = res_coarse_q;
    assign res.res_fine   = res_fine_q;
    assign res.res_sat    = res_sat_q;
    assign dropped        = dropped_q;
    assign busy           = (state_q == ARMED) || (state_q == IN_PULSE);
endmodule

// File: tb/tb_afe_pulse_capture.sv
// Directed bench for afe_pulse_capture: hand-computed edge positions, widths and timestamps.
module tb_afe_pulse_capture;
    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic        y0;
    logic        arm;
    logic        arm2;
    logic        dropped, busy;
    logic        dropped2, busy2;
    logic [31:0] tbcnt;
    logic [31:0] c;
    logic [31:0] c12;
    int          total;
    int          bad;

    afe_pulse_capture_if #(.WIDTH_BITS(16), .COARSE_BITS(32)) rif ();
    afe_pulse_capture_if #(.WIDTH_BITS(4),  .COARSE_BITS(32)) rif2 ();

    afe_pulse_capture #(.WIDTH_BITS(16), .COARSE_BITS(32)) dut (
        .lclk       (clk),
        .lclk_rst_n (rst_n),
        .din        (din),
        .y0         (y0),
        .arm        (arm),
        .res        (rif),
        .dropped    (dropped),
        .busy       (busy)
    );

    afe_pulse_capture #(.WIDTH_BITS(4), .COARSE_BITS(32)) dut_sat (
        .lclk       (clk),
        .lclk_rst_n (rst_n),
        .din        (din),
        .y0         (y0),
        .arm        (arm2),
        .res        (rif2),
        .dropped    (dropped2),
        .busy       (busy2)
    );

    always #5 clk = ~clk;

    // Reference timestamp: lclk edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tbcnt <= '0;
        else        tbcnt <= tbcnt + 32'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic word(input logic [7:0] w);
        din = w;
        @(negedge clk);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic ack(input string tag);
        rif.res_ready = 1'b1;
        @(negedge clk);
        rif.res_ready = 1'b0;
        chk(tag, rif.res_valid, 1'b0);
    endtask

    initial begin
        total = 0; bad = 0;
        clk = 0; rst_n = 0; din = 8'h00; y0 = 0; arm = 0; arm2 = 0;
        rif.res_ready = 0; rif2.res_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid",   rif.res_valid,  1'b0);
        chk("rst_busy",    busy,           1'b0);
        chk("rst_dropped", dropped,        1'b0);
        chk("rst_width",   rif.res_width,  16'd0);
        chk("rst_coarse",  rif.res_coarse, 32'd0);
        chk("rst_fine",    rif.res_fine,   3'd0);
        chk("rst_sat",     rif.res_sat,    1'b0);
        chk("rst_valid2",  rif2.res_valid, 1'b0);
        rst_n = 1;
        @(negedge clk);

        // Multi-word pulse: 5 + 8 + 4 ticks
        do_arm();
        chk("t1_busy_armed", busy, 1'b1);
        word(8'h00);
        c = tbcnt;
        word(8'hF8);
        chk("t1_busy_inpulse", busy, 1'b1);
        word(8'hFF);
        word(8'h0F);
        chk("t1_valid_done_cycle", rif.res_valid, 1'b0);
        word(8'h00);
        chk("t1_valid",   rif.res_valid,  1'b1);
        chk("t1_width",   rif.res_width,  16'd17);
        chk("t1_fine",    rif.res_fine,   3'd3);
        chk("t1_coarse",  rif.res_coarse, c);
        chk("t1_sat",     rif.res_sat,    1'b0);
        chk("t1_dropped", dropped,        1'b0);
        chk("t1_busy",    busy,           1'b0);
        ack("t1_ack");

        // In-word pulses
        do_arm();
        c = tbcnt;
        word(8'h18);
        word(8'h00);
        chk("t2a_valid",   rif.res_valid,  1'b1);
        chk("t2a_fine",    rif.res_fine,   3'd3);
        chk("t2a_width",   rif.res_width,  16'd2);
        chk("t2a_coarse",  rif.res_coarse, c);
        chk("t2a_dropped", dropped,        1'b0);
        ack("t2a_ack");
        do_arm();
        c = tbcnt;
        word(8'h5A);
        word(8'h00);
        chk("t2b_fine",    rif.res_fine,   3'd1);
        chk("t2b_width",   rif.res_width,  16'd1);
        chk("t2b_coarse",  rif.res_coarse, c);
        chk("t2b_dropped", dropped,        1'b1);
        ack("t2b_ack");

        // Line already active when armed
        din = 8'hFF;
        do_arm();
        chk("t3_dropped_cleared", dropped, 1'b0);
        word(8'hFF);
        chk("t3_still_armed", busy, 1'b1);
        word(8'h00);
        c = tbcnt;
        word(8'h01);
        word(8'h00);
        chk("t3_valid",  rif.res_valid,  1'b1);
        chk("t3_fine",   rif.res_fine,   3'd0);
        chk("t3_width",  rif.res_width,  16'd1);
        chk("t3_coarse", rif.res_coarse, c);
        ack("t3_ack");

        // Idle level high
        y0 = 1;
        din = 8'hFF;
        do_arm();
        word(8'hFF);
        c = tbcnt;
        word(8'hE7);
        word(8'hFF);
        chk("t4_valid",  rif.res_valid,  1'b1);
        chk("t4_fine",   rif.res_fine,   3'd3);
        chk("t4_width",  rif.res_width,  16'd2);
        chk("t4_coarse", rif.res_coarse, c);
        ack("t4_ack");
        y0 = 0;
        din = 8'h00;

        // Backpressure: second result discarded
        do_arm();
        word(8'h00);
        c12 = tbcnt;
        word(8'hF0);
        word(8'hFF);
        word(8'h00);
        word(8'h00);
        chk("t5_valid12", rif.res_valid, 1'b1);
        chk("t5_width12", rif.res_width, 16'd12);
        do_arm();
        word(8'hFE);
        word(8'h00);
        word(8'h00);
        chk("t5_valid_kept", rif.res_valid,  1'b1);
        chk("t5_width_kept", rif.res_width,  16'd12);
        chk("t5_fine_kept",  rif.res_fine,   3'd4);
        chk("t5_coarse_kept", rif.res_coarse, c12);
        chk("t5_dropped",    dropped,        1'b1);
        ack("t5_ack");

        // Handshake in the same cycle as DONE: new result replaces the old
        do_arm();
        word(8'h18);
        word(8'h00);
        chk("t6_old_width", rif.res_width, 16'd2);
        do_arm();
        c = tbcnt;
        word(8'h0E);
        rif.res_ready = 1'b1;
        word(8'h00);
        rif.res_ready = 1'b0;
        chk("t6_valid_stays", rif.res_valid,  1'b1);
        chk("t6_width",       rif.res_width,  16'd3);
        chk("t6_fine",        rif.res_fine,   3'd1);
        chk("t6_coarse",      rif.res_coarse, c);
        chk("t6_dropped",     dropped,        1'b0);
        ack("t6_ack");

        // Saturation on the 4-bit-width instance
        arm2 = 1'b1;
        @(negedge clk);
        arm2 = 1'b0;
        word(8'h00);
        c = tbcnt;
        word(8'hFF);
        word(8'hFF);
        word(8'hFF);
        word(8'h00);
        word(8'h00);
        chk("t7_valid",  rif2.res_valid,  1'b1);
        chk("t7_width",  rif2.res_width,  4'd15);
        chk("t7_sat",    rif2.res_sat,    1'b1);
        chk("t7_fine",   rif2.res_fine,   3'd0);
        chk("t7_coarse", rif2.res_coarse, c);
        chk("t7_main_idle", rif.res_valid, 1'b0);

        // Asynchronous reset in the middle of a pulse, with a result pending
        do_arm();
        word(8'h18);
        word(8'h00);
        chk("t8_pending", rif.res_valid, 1'b1);
        do_arm();
        word(8'h00);
        word(8'hF0);
        chk("t8_inpulse", busy, 1'b1);
        #2 rst_n = 0;
        #1;
        chk("t8_rst_valid",   rif.res_valid,  1'b0);
        chk("t8_rst_busy",    busy,           1'b0);
        chk("t8_rst_coarse",  rif.res_coarse, 32'd0);
        chk("t8_rst_valid2",  rif2.res_valid, 1'b0);
        @(negedge clk);
        rst_n = 1;
        word(8'h00);
        word(8'h00);
        word(8'h00);
        chk("t8_post_valid", rif.res_valid, 1'b0);
        chk("t8_post_busy",  busy,          1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
